// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer for the Spartan CPU core
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_bus,
    input  logic [2:0]  flags,
    input  logic        mem_ready,
    output logic        pc_increment,
    output logic        pc_load,
    output logic        memory_read,
    output logic        memory_write,
    output logic        cmp_load,
    output logic        cmp_compare,
    output logic        lu_passthrough,
    output logic        lu_add,
    output logic        lu_sub,
    output logic        lu_shr,
    output logic        lu_shl,
    output logic        lu_band,
    output logic        lu_bor,
    output logic        lu_bxor,
    output logic        lu_bnegate,
    output logic        reg1_read,
    output logic        reg2_read,
    output logic        reg3_write,
    output logic [3:0]  reg1_addr,
    output logic [3:0]  reg2_addr,
    output logic [3:0]  reg3_addr,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_CMP1,
        S_CMP2,
        S_HALT
    } state_t;

    // Strobes that are fixed for the whole duration of a state; they are
    // loaded on the edge that enters the state so they come straight from flops.
    typedef struct packed {
        logic       reg1_read;
        logic       reg2_read;
        logic       alu_write;
        logic       memory_read;
        logic       memory_write;
        logic       cmp_load;
        logic       cmp_compare;
        logic       halted;
        logic [8:0] lu;          // [0] passthrough .. [8] bnegate, one-hot or zero
    } ctl_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_CMP   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_BR    = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t      state;
    logic [15:0] ir;
    ctl_t        ctl;
    logic [3:0]  op;
    logic        br_take;
    logic        jump_taken;
    logic        mem_done;

    assign op = ir[15:12];

    // Sequencer: instruction latch, state transitions and held strobes for the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            ir    <= '0;
            ctl   <= '0;
        end else begin
            ctl <= '0;
            case (state)
                S_FETCH: begin
                    ir    <= i_bus;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_HALT: begin
                            state       <= S_HALT;
                            ctl.halted  <= 1'b1;
                        end
                        OP_LOAD: begin
                            state           <= S_MEM;
                            ctl.reg2_read   <= 1'b1;
                            ctl.memory_read <= 1'b1;
                        end
                        OP_STORE: begin
                            state            <= S_MEM;
                            ctl.reg1_read    <= 1'b1;
                            ctl.reg2_read    <= 1'b1;
                            ctl.lu[0]        <= 1'b1;
                            ctl.memory_write <= 1'b1;
                        end
                        OP_CMP: begin
                            state         <= S_CMP1;
                            ctl.reg1_read <= 1'b1;
                            ctl.reg2_read <= 1'b1;
                            ctl.cmp_load  <= 1'b1;
                        end
                        OP_JMP, OP_BR: begin
                            state         <= S_EXEC;
                            ctl.reg1_read <= 1'b1;
                            ctl.lu[0]     <= 1'b1;
                        end
                        default: begin
                            state         <= S_EXEC;
                            ctl.reg1_read <= 1'b1;
                            ctl.reg2_read <= 1'b1;
                            if (op != OP_NOP) begin
                                ctl.lu        <= 9'b1 << (op - 4'd1);
                                ctl.alu_write <= 1'b1;
                            end
                        end
                    endcase
                end
                S_MEM: begin
                    // Hold the access until the memory completes it
                    if (mem_ready) begin
                        state <= S_FETCH;
                    end else begin
                        ctl <= ctl;
                    end
                end
                S_CMP1: begin
                    state           <= S_CMP2;
                    ctl.cmp_compare <= 1'b1;
                end
                S_HALT: begin
                    ctl <= ctl;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Branch condition from IR rd[1:0]: 0 EQ, 1 LT, 2 GT, 3 always
    always_comb begin
        case (ir[9:8])
            2'd0:    br_take = flags[0];
            2'd1:    br_take = flags[1];
            2'd2:    br_take = flags[2];
            default: br_take = 1'b1;
        endcase
    end

    // Single-cycle PC and write-back strobes, qualified by flags / mem_ready in the retiring cycle
    always_comb begin
        jump_taken   = (state == S_EXEC) && ((op == OP_JMP) || ((op == OP_BR) && br_take));
        mem_done     = (state == S_MEM) && mem_ready;
        pc_load      = jump_taken;
        pc_increment = ((state == S_EXEC) && !jump_taken) || mem_done || (state == S_CMP2);
        reg3_write   = ctl.alu_write || (mem_done && (op == OP_LOAD));
    end

    assign memory_read    = ctl.memory_read;
    assign memory_write   = ctl.memory_write;
    assign cmp_load       = ctl.cmp_load;
    assign cmp_compare    = ctl.cmp_compare;
    assign lu_passthrough = ctl.lu[0];
    assign lu_add         = ctl.lu[1];
    assign lu_sub         = ctl.lu[2];
    assign lu_shr         = ctl.lu[3];
    assign lu_shl         = ctl.lu[4];
    assign lu_band        = ctl.lu[5];
    assign lu_bor         = ctl.lu[6];
    assign lu_bxor        = ctl.lu[7];
    assign lu_bnegate     = ctl.lu[8];
    assign reg1_read      = ctl.reg1_read;
    assign reg2_read      = ctl.reg2_read;
    assign halted         = ctl.halted;
    assign reg1_addr      = ir[7:4];
    assign reg2_addr      = ir[3:0];
    assign reg3_addr      = ir[11:8];

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit with a cycle-level reference model
module tb_control_unit;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_load;
        logic       mrd;
        logic       mwr;
        logic       cl;
        logic       cc;
        logic [8:0] lu;
        logic       r1;
        logic       r2;
        logic       r3w;
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] a3;
        logic       halted;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_bus;
    logic [2:0]  flags;
    logic        mem_ready;
    logic        pc_increment, pc_load, memory_read, memory_write, cmp_load, cmp_compare;
    logic        lu_passthrough, lu_add, lu_sub, lu_shr, lu_shl, lu_band, lu_bor, lu_bxor, lu_bnegate;
    logic        reg1_read, reg2_read, reg3_write, halted;
    logic [3:0]  reg1_addr, reg2_addr, reg3_addr;

    control_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_bus          (i_bus),
        .flags          (flags),
        .mem_ready      (mem_ready),
        .pc_increment   (pc_increment),
        .pc_load        (pc_load),
        .memory_read    (memory_read),
        .memory_write   (memory_write),
        .cmp_load       (cmp_load),
        .cmp_compare    (cmp_compare),
        .lu_passthrough (lu_passthrough),
        .lu_add         (lu_add),
        .lu_sub         (lu_sub),
        .lu_shr         (lu_shr),
        .lu_shl         (lu_shl),
        .lu_band        (lu_band),
        .lu_bor         (lu_bor),
        .lu_bxor        (lu_bxor),
        .lu_bnegate     (lu_bnegate),
        .reg1_read      (reg1_read),
        .reg2_read      (reg2_read),
        .reg3_write     (reg3_write),
        .reg1_addr      (reg1_addr),
        .reg2_addr      (reg2_addr),
        .reg3_addr      (reg3_addr),
        .halted         (halted)
    );

    out_t obs;
    assign obs = '{pc_inc: pc_increment, pc_load: pc_load, mrd: memory_read, mwr: memory_write,
                   cl: cmp_load, cc: cmp_compare,
                   lu: {lu_bnegate, lu_bxor, lu_bor, lu_band, lu_shl, lu_shr, lu_sub, lu_add, lu_passthrough},
                   r1: reg1_read, r2: reg2_read, r3w: reg3_write,
                   a1: reg1_addr, a2: reg2_addr, a3: reg3_addr, halted: halted};

    int          checks = 0;
    int          failures = 0;
    out_t        expq[$];
    logic [15:0] prev_w = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    // One compare process: every cycle with a queued expectation is checked mid-cycle
    always @(negedge clk) begin
        if (rst_n && expq.size() > 0) begin
            out_t e;
            e = expq.pop_front();
            check_vec("cycle", obs, e);
        end
    end

    // Idle cycles (FETCH/DECODE): no strobes, addresses follow the instruction held in IR
    function automatic out_t idle_vec(input logic [15:0] w);
        out_t e;
        e    = '0;
        e.a1 = w[7:4];
        e.a2 = w[3:0];
        e.a3 = w[11:8];
        return e;
    endfunction

    // Execute-phase outputs of instruction w; last selects the final MEM cycle or CMP2
    function automatic out_t exp_exec(input logic [15:0] w, input logic [2:0] f, input bit last);
        out_t e;
        int   op;
        int   cond;
        bit   take;
        e    = idle_vec(w);
        op   = int'(w[15:12]);
        cond = int'(w[9:8]);
        if (op <= 9) begin
            e.r1 = 1'b1; e.r2 = 1'b1; e.pc_inc = 1'b1;
            if (op != 0) begin
                e.lu[op-1] = 1'b1;
                e.r3w      = 1'b1;
            end
        end else begin
            case (op)
                10: begin
                    e.r2 = 1'b1; e.mrd = 1'b1;
                    if (last) begin e.r3w = 1'b1; e.pc_inc = 1'b1; end
                end
                11: begin
                    e.r1 = 1'b1; e.r2 = 1'b1; e.lu[0] = 1'b1; e.mwr = 1'b1;
                    if (last) e.pc_inc = 1'b1;
                end
                12: begin
                    if (!last) begin e.r1 = 1'b1; e.r2 = 1'b1; e.cl = 1'b1; end
                    else begin e.cc = 1'b1; e.pc_inc = 1'b1; end
                end
                13: begin
                    e.r1 = 1'b1; e.lu[0] = 1'b1; e.pc_load = 1'b1;
                end
                14: begin
                    e.r1 = 1'b1; e.lu[0] = 1'b1;
                    take = (cond == 3) || (f[cond] == 1'b1);
                    if (take) e.pc_load = 1'b1;
                    else      e.pc_inc  = 1'b1;
                end
                default: e.halted = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH entry; n = MEM wait cycles, f = flags at BR,
    // abort_at >= 0 asserts reset in that MEM cycle instead of completing it
    task automatic run_instr(input logic [15:0] w, input int n, input logic [2:0] f, input int abort_at);
        int op;
        op        = int'(w[15:12]);
        i_bus     = w;
        flags     = 3'($urandom);
        mem_ready = 1'($urandom);
        expq.push_back(idle_vec(prev_w));
        step();
        i_bus     = 16'($urandom);
        flags     = 3'($urandom);
        mem_ready = 1'($urandom);
        expq.push_back(idle_vec(w));
        step();
        prev_w = w;
        if (op == 10 || op == 11) begin
            for (int k = 0; k <= n; k++) begin
                i_bus = 16'($urandom);
                flags = 3'($urandom);
                if (k == abort_at) begin
                    mem_ready = 1'b0;
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check_bit("rst_mw_drop", memory_write, 1'b0);
                    check_bit("rst_mr_drop", memory_read, 1'b0);
                    check_vec("rst_in_mem", obs, '0);
                    step();
                    prev_w = 16'h0000;
                    return;
                end
                mem_ready = (k == n);
                expq.push_back(exp_exec(w, f, k == n));
                step();
            end
        end else if (op == 12) begin
            expq.push_back(exp_exec(w, f, 1'b0));
            step();
            expq.push_back(exp_exec(w, f, 1'b1));
            step();
        end else if (op == 15) begin
            for (int k = 0; k < 20; k++) begin
                i_bus     = 16'($urandom);
                flags     = 3'($urandom);
                mem_ready = 1'($urandom);
                expq.push_back(exp_exec(w, f, 1'b1));
                step();
            end
        end else begin
            flags     = f;
            mem_ready = 1'($urandom);
            expq.push_back(exp_exec(w, f, 1'b1));
            step();
        end
    endtask

    // Called at cycle start with rst_n possibly already low; leaves the DUT in FETCH at cycle start
    task automatic hold_reset();
        rst_n = 1'b0;
        #1;
        check_vec("rst_async", obs, '0);
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b1;
            i_bus     = 16'($urandom);
            @(negedge clk);
            check_bit("rst_no_pc_inc", pc_increment, 1'b0);
            check_bit("rst_halted", halted, 1'b0);
            step();
        end
        rst_n  = 1'b1;
        prev_w = 16'h0000;
    endtask

    initial begin
        out_t lit;
        logic [15:0] w;
        int          op;

        rst_n     = 1'b0;
        i_bus     = 16'h0000;
        flags     = 3'b000;
        mem_ready = 1'b0;
        #3;
        check_vec("reset_state", obs, '0);
        step();
        rst_n = 1'b1;

        // Model pins against hand-derived vectors
        lit = '0; lit.pc_inc = 1; lit.lu[1] = 1; lit.r1 = 1; lit.r2 = 1; lit.r3w = 1;
        lit.a1 = 4'd1; lit.a2 = 4'd2; lit.a3 = 4'd3;
        check_vec("pin_add", exp_exec(16'h2312, 3'b000, 1'b1), lit);
        lit = '0; lit.r2 = 1; lit.mrd = 1; lit.a2 = 4'd4; lit.a3 = 4'd5;
        check_vec("pin_load_wait", exp_exec(16'hA504, 3'b000, 1'b0), lit);
        lit.r3w = 1; lit.pc_inc = 1;
        check_vec("pin_load_done", exp_exec(16'hA504, 3'b000, 1'b1), lit);
        lit = '0; lit.r1 = 1; lit.lu[0] = 1; lit.pc_load = 1; lit.a1 = 4'd7;
        check_vec("pin_br_taken", exp_exec(16'hE070, 3'b001, 1'b1), lit);
        lit.pc_load = 0; lit.pc_inc = 1;
        check_vec("pin_br_not", exp_exec(16'hE070, 3'b010, 1'b1), lit);

        // Directed sequences from the test plan
        run_instr(16'h2312, 0, 3'b000, -1);
        run_instr(16'hA504, 2, 3'b000, -1);
        run_instr(16'hC012, 0, 3'b000, -1);
        run_instr(16'hE070, 0, 3'b001, -1);
        run_instr(16'hC012, 0, 3'b000, -1);
        run_instr(16'hE070, 0, 3'b010, -1);
        run_instr(16'hA504, 0, 3'b000, -1);
        run_instr(16'hF000, 0, 3'b000, -1);
        hold_reset();
        run_instr(16'hB012, 3, 3'b000, 1);
        hold_reset();

        // Randomized instruction stream, with an occasional HALT recovered by reset
        for (int i = 0; i < 250; i++) begin
            w  = 16'($urandom);
            op = int'(w[15:12]);
            if (op == 15 && ($urandom_range(0, 3) != 0)) w[15:12] = 4'($urandom_range(0, 14));
            run_instr(w, int'($urandom_range(0, 3)), 3'($urandom), -1);
            if (w[15:12] == 4'hF) hold_reset();
        end

        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction sequencer for the Spartan CPU core. It latches each 16-bit instruction from the instruction bus, decodes it, and drives the strobes for the register file, program counter, comparator, logic unit and data memory, one instruction at a time. It sits at the top level beside those datapath blocks and drives their control nets.

## Interface

Parameters:
- none

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_bus  input  16  instruction word at current PC, valid combinationally
- flags  input  3  comparator flags: [0] EQ, [1] LT, [2] GT
- mem_ready  input  1  data memory completes the current read/write this cycle
- pc_increment, pc_load  output  1 each  program counter strobes
- memory_read, memory_write  output  1 each  data memory strobes
- cmp_load, cmp_compare  output  1 each  comparator strobes
- lu_passthrough, lu_add, lu_sub, lu_shr, lu_shl, lu_band, lu_bor, lu_bxor, lu_bnegate  output  1 each  logic unit op select, at most one high
- reg1_read, reg2_read, reg3_write  output  1 each  register file port enables
- reg1_addr, reg2_addr, reg3_addr  output  4 each  register file addresses
- halted  output  1  high once HALT has executed

Clock is `clk`. Reset is `rst_n`, asynchronous, active-low.

## Operation

- Instruction format: op=[15:12], rd=[11:8], rs1=[7:4], rs2=[3:0]. Addresses are driven from the instruction register (IR): reg1_addr=rs1, reg2_addr=rs2, reg3_addr=rd.
- Opcodes:
  - 0 NOP.
  - 1 MOV: passthrough.
  - 2 ADD, 3 SUB, 4 SHR, 5 SHL, 6 AND, 7 OR, 8 XOR, 9 NOT.
  - A LOAD: rd <= mem[rs2].
  - B STORE: mem[rs2] <= rs1.
  - C CMP: rs1 vs rs2.
  - D JMP: PC <= rs1.
  - E BR: PC <= rs1 if the condition holds. rd[1:0] selects the condition: 0 EQ, 1 LT, 2 GT, 3 always.
  - F HALT.
- States:
  - FETCH: IR <= i_bus. Goes to DECODE.
  - DECODE: no strobes. Goes to HALT for F, MEM for A/B, CMP1 for C, otherwise EXEC.
  - EXEC (NOP, 1–9): reg1_read and reg2_read are high. For ops 1–9 the matching lu_* and reg3_write are also high. pc_increment is high. Goes to FETCH.
  - EXEC (D, E): reg1_read and lu_passthrough are high.
    - D, or E with the condition true: pc_load.
    - E with the condition false: pc_increment.
    - Goes to FETCH.
  - MEM, LOAD: reg2_read and memory_read are held high. In the cycle mem_ready=1, reg3_write and pc_increment are high, then the FSM goes to FETCH.
  - MEM, STORE: reg1_read, reg2_read, lu_passthrough and memory_write are held high. In the cycle mem_ready=1, pc_increment is high, then the FSM goes to FETCH.
  - CMP1: reg1_read, reg2_read and cmp_load are high. Goes to CMP2.
  - CMP2: cmp_compare and pc_increment are high. Goes to FETCH.
  - HALT: halted=1 and no other strobes. The FSM stays here until reset.
- Invariants:
  - Exactly one of pc_increment or pc_load is pulsed per retired instruction, and only in its final cycle.
  - memory_read and memory_write are never high together.
- Outputs are decoded from the registered state and IR only, never combinationally from i_bus. flags and mem_ready qualify only the single-cycle PC and write strobes.
- BR samples flags in its EXEC cycle. A CMP immediately before it has already updated them in CMP2.

## Timing

- Reset (rst_n=0): state=FETCH, IR=0, halted=0, all strobes and addresses 0. This takes effect immediately, without waiting for clk.
- Reset asserted during MEM: memory_read and memory_write drop asynchronously, and no write-back or PC update occurs.
- Latency from FETCH entry to retire:
  - NOP, ALU, JMP, BR: 3 cycles.
  - CMP: 4 cycles.
  - LOAD, STORE: 3+N cycles, where N is the number of cycles mem_ready is low in MEM.
- mem_ready outside MEM is ignored.
- A mem_ready pulse in the first MEM cycle gives the minimum 3-cycle access.
- PC strobes are single-cycle pulses. The next FETCH sees the updated i_addr.

## Test plan

- Reset mid-run:
  - Stimulus: rst_n low mid-run, then release.
  - Required: all outputs 0 immediately; halted=0; first FETCH on the first edge after release.
- ADD:
  - Stimulus: i_bus=0x2312.
  - Required: in cycle 3, lu_add=1, reg1_addr=1, reg2_addr=2, reg3_addr=3, reg3_write=1, pc_increment=1; all other lu_*=0.
- LOAD with wait states:
  - Stimulus: i_bus=0xA504, mem_ready low for 2 MEM cycles.
  - Required: memory_read high for 3 cycles with reg2_addr=4; reg3_write=1 with reg3_addr=5 and pc_increment only in the third MEM cycle.
- CMP then branch on EQ:
  - Stimulus: 0xC012, then 0xE070.
  - Required: cmp_load then cmp_compare on consecutive cycles. With flags=3'b001, BR asserts pc_load with lu_passthrough and reg1_addr=7. With flags=3'b010, BR asserts pc_increment only.
- HALT:
  - Stimulus: i_bus=0xF000.
  - Required: halted=1 from cycle 3, no further PC or memory strobes for 20 cycles regardless of i_bus.
- Reset during STORE wait:
  - Stimulus: STORE 0xB012, rst_n pulsed low during its wait.
  - Required: memory_write drops within the reset cycle, and no pc_increment occurs for that instruction.
